// File: rtl/bit_scan_reader_pkg.sv
// rtl/bit_scan_reader_pkg.sv - shared constants and state type for the bit scan reader
package bit_scan_reader_pkg;
    localparam int ADDR_W = 6;
    localparam int WORD_W = 4;
    localparam int DEPTH  = 16;
    localparam logic [ADDR_W-1:0] FRAME_LAST = 6'd63;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ERR
    } state_t;
endpackage

// File: rtl/bit_scan_reader_tick_sync_edge.sv
// rtl/bit_scan_reader_tick_sync_edge.sv - tick synchroniser with single-cycle rise detect
module tick_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
endmodule

// File: rtl/bit_scan_reader.sv
// rtl/bit_scan_reader.sv - serialises a 16x4 register file under tick control, counts ones per frame
module bit_scan_reader
    import bit_scan_reader_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CHECK_SEQ   = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic [3:0] rg_a,
    input  logic [1:0] bit_a,
    input  logic       we,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       bit_out,
    output logic       bit_valid,
    output logic [6:0] ones_cnt,
    output logic       frame_done,
    output logic       seq_err
);
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic              bit_out_q, bit_out_d;
    logic              bit_valid_q, bit_valid_d;
    logic [6:0]        ones_cnt_q, ones_cnt_d;
    logic              frame_done_q, frame_done_d;
    logic [6:0]        acc_q, acc_d;
    logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
    state_t            state_q, state_d;

    logic              rise;
    logic [ADDR_W-1:0] addr;
    logic              smp_bit;

    tick_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
        .clk  (clk),
        .clr  (clr),
        .din  (tick),
        .rise (rise)
    );

    assign addr    = {rg_a, bit_a};
    // Read from the registered array so a same-cycle write returns old data
    assign smp_bit = mem_q[rg_a][bit_a];

    always_comb begin
        mem_d        = mem_q;
        bit_out_d    = bit_out_q;
        bit_valid_d  = 1'b0;
        ones_cnt_d   = ones_cnt_q;
        frame_done_d = 1'b0;
        acc_d        = acc_q;
        prev_addr_d  = prev_addr_q;
        state_d      = state_q;

        if (we) begin
            mem_d[wr_addr] = wr_data;
        end

        if (rise) begin
            bit_out_d   = smp_bit;
            bit_valid_d = 1'b1;
            prev_addr_d = addr;
            acc_d       = (addr == '0) ? {6'd0, smp_bit} : acc_q + {6'd0, smp_bit};
            if (addr == FRAME_LAST) begin
                frame_done_d = 1'b1;
                ones_cnt_d   = acc_q + {6'd0, smp_bit};
            end
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   if (CHECK_SEQ != 0 && addr != prev_addr_q + 6'd1) state_d = S_ERR;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mem_q        <= '{default: '0};
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            ones_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            acc_q        <= '0;
            prev_addr_q  <= '0;
            state_q      <= S_IDLE;
        end else begin
            mem_q        <= mem_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            ones_cnt_q   <= ones_cnt_d;
            frame_done_q <= frame_done_d;
            acc_q        <= acc_d;
            prev_addr_q  <= prev_addr_d;
            state_q      <= state_d;
        end
    end

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign ones_cnt   = ones_cnt_q;
    assign frame_done = frame_done_q;
    assign seq_err    = (state_q == S_ERR);
endmodule
